// File: rtl/pipe_hazard_ctrl.sv
// Hazard, flush and branch-prediction controller for the 5-stage pipeline.
// Resolves branches/jumps in MEM, stalls on load-use and trains a 2-bit BHT.
module pipe_hazard_ctrl #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] IF_PCIdx,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_useRs,
   input  logic             ID_useRt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_writeReg,
   input  logic [1:0]       MEM_Branch,
   input  logic             MEM_zero,
   input  logic             MEM_Jump,
   input  logic             MEM_jr,
   input  logic             MEM_Predict,
   input  logic [IDX_W-1:0] MEM_PCIdx,
   output logic             IF_Predict,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic             EX_MEM_Bubble,
   output logic [2:0]       PC_Sel,
   output logic [CNT_W-1:0] BranchCnt,
   output logic [CNT_W-1:0] MispredCnt
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [1:0] bht [ENTRIES];
   logic       isBr;
   logic       taken;
   logic       mispred;
   logic       redirect;
   logic       loadUse;

   always_comb begin
      isBr     = (MEM_Branch == 2'b01) || (MEM_Branch == 2'b10);
      taken    = ((MEM_Branch == 2'b01) && MEM_zero) || ((MEM_Branch == 2'b10) && !MEM_zero);
      mispred  = isBr && (taken != MEM_Predict);
      redirect = mispred || MEM_Jump || MEM_jr;
      loadUse  = EX_MemRead && (EX_writeReg != 5'd0) &&
                 ((ID_useRs && (ID_rs == EX_writeReg)) || (ID_useRt && (ID_rt == EX_writeReg)));
   end

   // Redirect squashes younger stages, so it overrides any load-use stall.
   always_comb begin
      PC_Write      = 1'b1;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Bubble  = 1'b0;
      EX_MEM_Bubble = 1'b0;
      PC_Sel        = 3'd0;
      IF_Predict    = bht[IF_PCIdx][1];
      if (reset) begin
         PC_Write      = 1'b0;
         IF_ID_Write   = 1'b0;
         IF_ID_Flush   = 1'b1;
         ID_EX_Bubble  = 1'b1;
         EX_MEM_Bubble = 1'b1;
         IF_Predict    = 1'b0;
      end else if (redirect) begin
         IF_ID_Flush   = 1'b1;
         ID_EX_Bubble  = 1'b1;
         EX_MEM_Bubble = 1'b1;
         if (MEM_jr)
            PC_Sel = 3'd4;
         else if (MEM_Jump)
            PC_Sel = 3'd3;
         else if (taken)
            PC_Sel = 3'd1;
         else
            PC_Sel = 3'd2;
      end else if (loadUse) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end
   end

   // Saturating 2-bit counters; the fetch read sees the pre-edge value.
   always_ff @(posedge Clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++)
            bht[i] <= 2'b01;
      end else if (isBr) begin
         if (taken && (bht[MEM_PCIdx] != 2'b11))
            bht[MEM_PCIdx] <= bht[MEM_PCIdx] + 2'b01;
         else if (!taken && (bht[MEM_PCIdx] != 2'b00))
            bht[MEM_PCIdx] <= bht[MEM_PCIdx] - 2'b01;
      end
   end

   // Performance counters stick at all-ones rather than wrapping.
   always_ff @(posedge Clk) begin
      if (reset) begin
         BranchCnt  <= '0;
         MispredCnt <= '0;
      end else begin
         if (isBr && (BranchCnt != {CNT_W{1'b1}}))
            BranchCnt <= BranchCnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (mispred && (MispredCnt != {CNT_W{1'b1}}))
            MispredCnt <= MispredCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

   localparam int IDX_W = 6;
   localparam int CNT_W = 8;

   typedef struct packed {
      logic       reset;
      logic [5:0] ifIdx;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       useRs;
      logic       useRt;
      logic       memRead;
      logic [4:0] writeReg;
      logic [1:0] branch;
      logic       zero;
      logic       jump;
      logic       jr;
      logic       predict;
      logic [5:0] memIdx;
   } stim_t;

   typedef struct {
      string      name;
      logic [7:0] ctrl;
      logic       pred;
      logic [7:0] br;
      logic [7:0] mis;
   } exp_t;

   localparam logic [7:0] IDLE  = 8'b11_000_000;
   localparam logic [7:0] STALL = 8'b00_010_000;
   localparam logic [7:0] RST   = 8'b00_111_000;

   logic             Clk = 1'b0;
   logic             reset;
   logic [IDX_W-1:0] IF_PCIdx, MEM_PCIdx;
   logic [4:0]       ID_rs, ID_rt, EX_writeReg;
   logic             ID_useRs, ID_useRt, EX_MemRead;
   logic [1:0]       MEM_Branch;
   logic             MEM_zero, MEM_Jump, MEM_jr, MEM_Predict;
   logic             IF_Predict, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble;
   logic [2:0]       PC_Sel;
   logic [CNT_W-1:0] BranchCnt, MispredCnt;

   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;

   pipe_hazard_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .reset(reset), .IF_PCIdx(IF_PCIdx), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_useRs(ID_useRs), .ID_useRt(ID_useRt), .EX_MemRead(EX_MemRead),
      .EX_writeReg(EX_writeReg), .MEM_Branch(MEM_Branch), .MEM_zero(MEM_zero),
      .MEM_Jump(MEM_Jump), .MEM_jr(MEM_jr), .MEM_Predict(MEM_Predict),
      .MEM_PCIdx(MEM_PCIdx), .IF_Predict(IF_Predict), .PC_Write(PC_Write),
      .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
      .EX_MEM_Bubble(EX_MEM_Bubble), .PC_Sel(PC_Sel), .BranchCnt(BranchCnt),
      .MispredCnt(MispredCnt)
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] redir(input logic [2:0] sel);
      return {5'b11111, sel};
   endfunction

   task automatic drive(input stim_t s);
      reset       = s.reset;
      IF_PCIdx    = s.ifIdx;
      ID_rs       = s.rs;
      ID_rt       = s.rt;
      ID_useRs    = s.useRs;
      ID_useRt    = s.useRt;
      EX_MemRead  = s.memRead;
      EX_writeReg = s.writeReg;
      MEM_Branch  = s.branch;
      MEM_zero    = s.zero;
      MEM_Jump    = s.jump;
      MEM_jr      = s.jr;
      MEM_Predict = s.predict;
      MEM_PCIdx   = s.memIdx;
   endtask

   task automatic applyStimulus(input string name, input stim_t s, input logic [7:0] ctrl,
                                input logic pred, input logic [7:0] br, input logic [7:0] mis);
      exp_t e;
      @(posedge Clk);
      #1;
      drive(s);
      e.name = name; e.ctrl = ctrl; e.pred = pred; e.br = br; e.mis = mis;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic [7:0] ctrl;
      ctrl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, PC_Sel};
      checks++;
      if (ctrl !== e.ctrl) begin
         errors++;
         $display("[TB] FAIL %s ctrl got %b expected %b", e.name, ctrl, e.ctrl);
      end
      checks++;
      if (IF_Predict !== e.pred) begin
         errors++;
         $display("[TB] FAIL %s IF_Predict got %b expected %b", e.name, IF_Predict, e.pred);
      end
      checks++;
      if (BranchCnt !== e.br || MispredCnt !== e.mis) begin
         errors++;
         $display("[TB] FAIL %s counters got %0d/%0d expected %0d/%0d",
                  e.name, BranchCnt, MispredCnt, e.br, e.mis);
      end
   endtask

   // Monitor: outputs are compared mid-cycle, away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      stim_t s;
      int    br, mis;
      s = '0;
      s.reset = 1'b1;
      drive(s);
      repeat (2) @(posedge Clk);

      applyStimulus("reset", s, RST, 1'b0, 8'd0, 8'd0);

      s = '0; s.ifIdx = 6'd5;
      applyStimulus("idle", s, IDLE, 1'b0, 8'd0, 8'd0);

      s.memRead = 1'b1; s.writeReg = 5'd8; s.rs = 5'd8; s.useRs = 1'b1;
      applyStimulus("loaduse_rs", s, STALL, 1'b0, 8'd0, 8'd0);

      s.writeReg = 5'd0; s.rs = 5'd0;
      applyStimulus("loaduse_r0", s, IDLE, 1'b0, 8'd0, 8'd0);

      s.useRs = 1'b0; s.useRt = 1'b1; s.rt = 5'd9; s.writeReg = 5'd9;
      applyStimulus("loaduse_rt", s, STALL, 1'b0, 8'd0, 8'd0);

      s = '0; s.ifIdx = 6'd5; s.memIdx = 6'd5;
      s.branch = 2'b01; s.zero = 1'b1; s.predict = 1'b0;
      applyStimulus("mispred_taken", s, redir(3'd1), 1'b0, 8'd0, 8'd0);

      s.branch = 2'b10; s.zero = 1'b0; s.predict = 1'b1;
      applyStimulus("correct_bne", s, IDLE, 1'b1, 8'd1, 8'd1);

      s.branch = 2'b10; s.zero = 1'b1; s.predict = 1'b1;
      applyStimulus("mispred_nt", s, redir(3'd2), 1'b1, 8'd2, 8'd1);

      s.branch = 2'b01; s.zero = 1'b0; s.predict = 1'b0;
      applyStimulus("correct_beq_nt", s, IDLE, 1'b1, 8'd3, 8'd2);

      s = '0; s.ifIdx = 6'd5;
      applyStimulus("bht_after_nt", s, IDLE, 1'b0, 8'd4, 8'd2);

      s.jr = 1'b1; s.jump = 1'b1; s.memRead = 1'b1; s.writeReg = 5'd8; s.rs = 5'd8; s.useRs = 1'b1;
      applyStimulus("prio_jr", s, redir(3'd4), 1'b0, 8'd4, 8'd2);

      s = '0; s.ifIdx = 6'd5; s.jump = 1'b1;
      applyStimulus("jump", s, redir(3'd3), 1'b0, 8'd4, 8'd2);

      s = '0; s.ifIdx = 6'd7; s.branch = 2'b11; s.zero = 1'b1; s.memIdx = 6'd7;
      applyStimulus("reserved_br", s, IDLE, 1'b0, 8'd4, 8'd2);

      for (int k = 0; k < 260; k++) begin
         s = '0; s.ifIdx = 6'd9; s.memIdx = 6'd9;
         s.branch = 2'b01; s.zero = 1'b1; s.predict = 1'b0;
         br  = (4 + k > 255) ? 255 : 4 + k;
         mis = (2 + k > 255) ? 255 : 2 + k;
         applyStimulus("saturate", s, redir(3'd1), (k == 0) ? 1'b0 : 1'b1, 8'(br), 8'(mis));
      end

      s.reset = 1'b1;
      applyStimulus("reset_midflush", s, RST, 1'b0, 8'd255, 8'd255);

      s = '0; s.ifIdx = 6'd9;
      applyStimulus("post_reset_idx9", s, IDLE, 1'b0, 8'd0, 8'd0);

      s.ifIdx = 6'd5;
      applyStimulus("post_reset_idx5", s, IDLE, 1'b0, 8'd0, 8'd0);

      for (int i = 0; i < 10 && sb.size() > 0; i++)
         @(posedge Clk);
      @(posedge Clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain pending %0d expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
